// File: rtl/flaf_pkg.sv
// ---------------------------------------------------------------------------
// flaf_pkg
// Shared constants and types for the functional-link weight combiner:
// default expansion order, word width, fractional bits, accumulator width
// and the controller state encoding. Imported by the combiner and by the
// blocks that produce/consume the phi expansion and weight updates.
// ---------------------------------------------------------------------------
package flaf_pkg;

  // Number of expansion terms per sample (x, then sin/cos pairs).
  localparam int Q_ORD = 7;
  // Signed word width of phi terms, weights, mu_e and y.
  localparam int WIDTH = 16;
  // Fractional bits of all Q-format words.
  localparam int QP    = 15;
  // Full-precision dot-product accumulator: 2*WIDTH product plus growth
  // headroom for summing Q_ORD of them.
  localparam int ACC_W = 2 * WIDTH + $clog2(Q_ORD);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MAC      = 3'd1,
    OUT      = 3'd2,
    WAIT_ERR = 3'd3,
    UPD      = 3'd4
  } state_e;

  // Width of a counter that walks 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rnd_sat.sv
// ---------------------------------------------------------------------------
// rnd_sat
// Round-half-up arithmetic right shift followed by signed saturation:
//   dout = sat_OUT_W((din + 2^(SHIFT-1)) >>> SHIFT)
// Purely combinational. SHIFT must be at least 1 and OUT_W must be
// narrower than IN_W + 1.
//
// Ports
//   din   in   IN_W   signed input value
//   dout  out  OUT_W  rounded, shifted, saturated result
// ---------------------------------------------------------------------------
module rnd_sat #(
  parameter int IN_W  = 35,
  parameter int SHIFT = 15,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  // One extra bit so that adding the rounding constant can never wrap.
  localparam int EXT_W = IN_W + 1;

  localparam logic signed [EXT_W-1:0] HALF  = EXT_W'(1) <<< (SHIFT - 1);
  localparam logic signed [EXT_W-1:0] MAX_V = (EXT_W'(1) <<< (OUT_W - 1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] MIN_V = -MAX_V - EXT_W'(1);

  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;

  // NOTE: every path through a combinational block assigns every output;
  // a branch that leaves one unassigned infers a latch.
  always_comb begin
    rounded = EXT_W'(din) + HALF;
    shifted = rounded >>> SHIFT;
    if (shifted > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
    end else begin
      dout = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/phi_weight_combiner.sv
// ---------------------------------------------------------------------------
// phi_weight_combiner
// Adaptive linear combiner for a functional-link expansion. Each accepted
// phi sample is dotted with Q_ORD stored weights (one term per cycle on a
// single shared multiplier), the rounded/saturated result is offered on
// y_out, and then the returned mu*e is used to update every weight
// (again one per cycle, on the same multiplier):
//   y    = sat((sum w[i]*phi[i] + 2^(QP-1)) >>> QP)
//   w[i] = sat(w[i] + ((mu_e*phi[i] + 2^(QP-1)) >>> QP))
//
// Ports
//   clk            in   1            clock, rising edge
//   rst            in   1            synchronous active-high reset
//   phi_in_packed  in   Q_ORD*WIDTH  phi terms, term i at [WIDTH*i +: WIDTH]
//   in_valid       in   1            phi sample valid
//   in_ready       out  1            block idle and able to take a sample
//   y_out          out  WIDTH        filter output Q(QP), held between outputs
//   out_valid      out  1            y_out offered
//   out_ready      in   1            consumer takes y_out
//   mu_e           in   WIDTH        step size times error, Q(QP)
//   err_valid      in   1            mu_e valid (only honoured after y taken)
//   busy           out  1            any state other than IDLE
// ---------------------------------------------------------------------------
module phi_weight_combiner
  import flaf_pkg::*;
#(
  parameter int Q_ORD = flaf_pkg::Q_ORD,
  parameter int WIDTH = flaf_pkg::WIDTH,
  parameter int QP    = flaf_pkg::QP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [Q_ORD*WIDTH-1:0]   phi_in_packed,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [WIDTH-1:0]  y_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic signed [WIDTH-1:0]  mu_e,
  input  logic                     err_valid,
  output logic                     busy
);

  localparam int ACC_W  = 2 * WIDTH + $clog2(Q_ORD);
  localparam int IDX_W  = idx_width(Q_ORD);
  localparam int PROD_W = 2 * WIDTH;
  // w << QP plus a full product needs one bit above the product width.
  localparam int UPD_W  = PROD_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Q_ORD - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                   state_q;
  state_e                   state_d;
  logic [IDX_W-1:0]         idx_q;
  logic signed [WIDTH-1:0]  phi_q [Q_ORD];
  logic signed [WIDTH-1:0]  w_q   [Q_ORD];
  logic signed [WIDTH-1:0]  mu_e_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [WIDTH-1:0]  y_q;

  // -------------------------------------------------------------------------
  // Shared datapath
  // -------------------------------------------------------------------------
  logic                     last_term;
  logic signed [WIDTH-1:0]  phi_sel;
  logic signed [WIDTH-1:0]  w_sel;
  logic signed [WIDTH-1:0]  mult_a;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [UPD_W-1:0]  upd_sum;
  logic signed [WIDTH-1:0]  y_rnd;
  logic signed [WIDTH-1:0]  w_upd;

  assign last_term = (idx_q == LAST_IDX);

  // One multiplier: weight x phi while accumulating, mu_e x phi while
  // updating. The phi operand is the same latched term in both phases.
  always_comb begin
    phi_sel  = phi_q[idx_q];
    w_sel    = w_q[idx_q];
    mult_a   = (state_q == UPD) ? mu_e_q : w_sel;
    prod     = PROD_W'(mult_a) * PROD_W'(phi_sel);
    acc_next = acc_q + ACC_W'(prod);
    // Rounding w + round(prod >>> QP) equals rounding (w << QP) + prod,
    // because the shifted weight contributes no fractional bits. This lets
    // a single round-shift-saturate produce the new weight directly.
    upd_sum  = (UPD_W'(w_sel) <<< QP) + UPD_W'(prod);
  end

  rnd_sat #(
    .IN_W  (ACC_W),
    .SHIFT (QP),
    .OUT_W (WIDTH)
  ) u_rnd_sat_y (
    .din  (acc_next),
    .dout (y_rnd)
  );

  rnd_sat #(
    .IN_W  (UPD_W),
    .SHIFT (QP),
    .OUT_W (WIDTH)
  ) u_rnd_sat_w (
    .din  (upd_sum),
    .dout (w_upd)
  );

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (in_valid)  state_d = MAC;
      MAC:      if (last_term) state_d = OUT;
      OUT:      if (out_ready) state_d = WAIT_ERR;
      WAIT_ERR: if (err_valid) state_d = UPD;
      UPD:      if (last_term) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (Moore)
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  assign y_out = y_q;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: the weight and phi arrays are reset explicitly; a reset mid-update
  // must leave no half-adapted weights behind, so they cannot be left as
  // unreset storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      acc_q  <= '0;
      mu_e_q <= '0;
      y_q    <= '0;
      for (int i = 0; i < Q_ORD; i++) begin
        phi_q[i] <= '0;
        w_q[i]   <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q <= '0;
            idx_q <= '0;
            for (int i = 0; i < Q_ORD; i++) begin
              phi_q[i] <= phi_in_packed[WIDTH*i +: WIDTH];
            end
          end
        end
        MAC: begin
          acc_q <= acc_next;
          idx_q <= last_term ? '0 : idx_q + 1'b1;
          // The final term's sum is rounded on the fly so y is ready the
          // same edge the controller enters OUT.
          if (last_term) begin
            y_q <= y_rnd;
          end
        end
        WAIT_ERR: begin
          if (err_valid) begin
            mu_e_q <= mu_e;
            idx_q  <= '0;
          end
        end
        UPD: begin
          w_q[idx_q] <= w_upd;
          idx_q      <= last_term ? '0 : idx_q + 1'b1;
        end
        default: begin
          idx_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/phi_weight_combiner.md
PHI_WEIGHT_COMBINER -- requirements
Module: phi_weight_combiner

Interface
REQ-001 The block SHALL have parameter Q_ORD, default 7, meaning the number of expansion terms per sample (x, then sin/cos pairs).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning the signed word width of each phi term, weight, mu_e and y.
REQ-003 The block SHALL have parameter QP, default 15, meaning the fractional bits of phi, weights, mu_e and y.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 phi_in_packed  input  Q_ORD*WIDTH  signed terms; term i occupies bits [WIDTH*i +: WIDTH].
REQ-007 in_valid / in_ready  input / output  1 each  phi sample handshake; transfer on a clock edge with both high.
REQ-008 y_out  output  WIDTH  signed filter output, Q(QP).
REQ-009 out_valid / out_ready  output / input  1 each  y handshake.
REQ-010 mu_e  input  WIDTH  signed step-size times error, Q(QP).
REQ-011 err_valid  input  1  mu_e is valid; used only in state WAIT_ERR.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL hold Q_ORD signed WIDTH-bit weights w[0..Q_ORD-1] in registers.
REQ-014 FSM states SHALL be IDLE, MAC, OUT, WAIT_ERR and UPD.
- IDLE: in_ready=1; on accept, latch all phi terms, clear acc, go to MAC.
- MAC: one term per cycle, i=0..Q_ORD-1; acc += w[i]*phi[i]; after term Q_ORD-1, go to OUT.
- OUT: out_valid=1, y_out stable; on out_ready, go to WAIT_ERR.
- WAIT_ERR: on err_valid, latch mu_e, go to UPD.
- UPD: one weight per cycle, i=0..Q_ORD-1; after term Q_ORD-1, go to IDLE.
REQ-015 in_ready SHALL be high only in IDLE; in_valid in any other state SHALL be ignored.
REQ-016 Timing from an accept edge T0: MAC occupies the next Q_ORD cycles; out_valid SHALL rise after edge T0+Q_ORD, first sampled high at edge T0+Q_ORD+1.
REQ-017 If out_ready is already high when out_valid rises, the transfer SHALL complete on that first edge.
REQ-018 err_valid outside WAIT_ERR SHALL be ignored; mu_e SHALL NOT be sampled at any other time.
REQ-019 Products SHALL be full 2*WIDTH signed; the accumulator SHALL be 2*WIDTH+clog2(Q_ORD) bits, so no internal overflow.
REQ-020 y SHALL be computed as (acc + 2^(QP-1)) >>> QP, then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-021 The weight update SHALL be w[i] <= sat(w[i] + ((mu_e*phi[i] + 2^(QP-1)) >>> QP)), saturating to WIDTH bits.
REQ-022 The update SHALL use the latched phi of the same sample.
REQ-023 y_out SHALL hold its last value outside OUT; out_valid SHALL be low outside OUT.

Reset
REQ-024 On rst high at a clock edge, from any state including mid-MAC or mid-UPD, the block SHALL apply all of the following:
- state=IDLE;
- all weights, acc, latched phi, latched mu_e and y_out = 0;
- out_valid=0, busy=0;
- in_ready=1 from the first cycle after reset.
REQ-025 A partially applied UPD SHALL be discarded entirely by reset.

Structure
REQ-026 Q_ORD, WIDTH, QP, ACC_W and the FSM state encoding SHALL live in a shared package/header flaf_pkg, reused by the expansion and update blocks.
REQ-027 Round-shift-saturate SHALL be one sub-module, rnd_sat, parameterised by input width, shift and output width, and instantiated for y and for weight update.
REQ-028 A single multiplier SHALL be time-shared between the MAC and UPD states.

Verification
REQ-029 Reset, then phi all 0x1000 -> y_out=0x0000, out_valid first high at edge T0+8.
REQ-030 Then mu_e=0x4000 -> every w=0x0800 after UPD; same phi again -> y_out=0x0700.
REQ-031 Two updates with phi all 0x7FFF and mu_e=0x7FFF, then the same phi -> weights 0x7FFF and y_out=0x7FFF (positive saturation); negated mu_e drives toward 0x8000.
REQ-032 Hold out_ready low 5 cycles -> y_out stable, in_ready=0, and an in_valid pulse in that window is ignored (no extra output).
REQ-033 Assert rst at the 3rd UPD cycle -> all weights 0, state IDLE, next output 0.
REQ-034 Pulse err_valid in IDLE and in MAC -> weights unchanged.
